// File: rtl/xbar_sched_pkg.sv
// Shared helpers and constants for the pipelined crossbar scheduler.
// Optional threshold masking is enabled with XBAR_SCHED_THRESH_EN.
package xbar_sched_pkg;

  localparam int MODE_MAX = 0;
  localparam int MODE_MIN = 1;

  // Entry width {v, len, id} for the default LEN_WIDTH=10, ID_WIDTH=5.
  localparam int ENTRY_W = 10 + 5 + 1;

  function automatic int pow2(input int width);
    return 1 << width;
  endfunction

  function automatic int stages(input int id_width, input int pipe_every);
    return (id_width + pipe_every - 1) / pipe_every;
  endfunction

  function automatic int entry_w(input int len_width, input int id_width);
    return len_width + id_width + 1;
  endfunction

endpackage

// File: rtl/xbar_sched_if.sv
// Valid/ready bus between the vector producer, the scheduler and the grant logic.
// The thresh signal exists only when XBAR_SCHED_THRESH_EN is defined.
interface xbar_sched_if #(
  parameter int LEN_WIDTH = 10,
  parameter int ID_WIDTH  = 5
);
  localparam int NUM_IN = 2 ** ID_WIDTH;

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_IN*LEN_WIDTH-1:0] in_len;
  logic [NUM_IN-1:0]           in_mask;
`ifdef XBAR_SCHED_THRESH_EN
  logic [LEN_WIDTH-1:0]        thresh;
`endif
  logic                        out_valid;
  logic                        out_ready;
  logic [LEN_WIDTH-1:0]        out_len;
  logic [ID_WIDTH-1:0]         out_id;
  logic                        out_found;

  modport master (
`ifdef XBAR_SCHED_THRESH_EN
    output thresh,
`endif
    output in_valid, in_len, in_mask, out_ready,
    input  in_ready, out_valid, out_len, out_id, out_found
  );

  modport slave (
`ifdef XBAR_SCHED_THRESH_EN
    input  thresh,
`endif
    input  in_valid, in_len, in_mask, out_ready,
    output in_ready, out_valid, out_len, out_id, out_found
  );
endinterface

// File: rtl/xbar_sched_node.sv
// One tournament node: picks the better of two (valid, len, id) entries.
// Ties go to input a, which always carries the lower queue ids.
module xbar_sched_node
  import xbar_sched_pkg::*;
#(
  parameter int LEN_WIDTH = 10,
  parameter int ID_WIDTH  = 5,
  parameter int MIN_MODE  = MODE_MAX
) (
  input  logic                 a_v,
  input  logic [LEN_WIDTH-1:0] a_len,
  input  logic [ID_WIDTH-1:0]  a_id,
  input  logic                 b_v,
  input  logic [LEN_WIDTH-1:0] b_len,
  input  logic [ID_WIDTH-1:0]  b_id,
  output logic                 y_v,
  output logic [LEN_WIDTH-1:0] y_len,
  output logic [ID_WIDTH-1:0]  y_id
);
  logic b_better, pick_b;

  // Strict compare so equal lengths keep input a.
  assign b_better = (MIN_MODE == MODE_MIN) ? (b_len < a_len) : (b_len > a_len);
  assign pick_b   = b_v && (!a_v || b_better);

  always_comb begin
    y_v   = a_v || b_v;
    y_len = '0;
    y_id  = '0;
    if (pick_b) begin
      y_len = b_len;
      y_id  = b_id;
    end else if (a_v) begin
      y_len = a_len;
      y_id  = a_id;
    end
  end
endmodule

// File: rtl/xbar_sched_pipe.sv
// Pipelined crossbar scheduler: comparator tree cut into register stages, global stall.
// Define XBAR_SCHED_THRESH_EN to mask leaves whose len is below bus.thresh.
module xbar_sched_pipe
  import xbar_sched_pkg::*;
#(
  parameter int LEN_WIDTH  = 10,
  parameter int ID_WIDTH   = 5,
  parameter int PIPE_EVERY = 1,
  parameter int MIN_MODE   = MODE_MAX
) (
  input  logic         clk,
  input  logic         rst,
  xbar_sched_if.slave  bus
);
  localparam int NUM_IN = pow2(ID_WIDTH);
  localparam int STAGES = stages(ID_WIDTH, PIPE_EVERY);
  localparam int EW     = entry_w(LEN_WIDTH, ID_WIDTH);

  // Heap-indexed tree: node n has children 2n and 2n+1, leaves at NUM_IN..2*NUM_IN-1.
  logic [2*NUM_IN-1:1]                ent_v;
  logic [2*NUM_IN-1:1][LEN_WIDTH-1:0] ent_len;
  logic [2*NUM_IN-1:1][ID_WIDTH-1:0]  ent_id;
  logic [NUM_IN-1:1]                  nd_v;
  logic [NUM_IN-1:1][LEN_WIDTH-1:0]   nd_len;
  logic [NUM_IN-1:1][ID_WIDTH-1:0]    nd_id;

  logic              adv;
  logic [STAGES:0]   vld_pipe;

  assign adv         = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;
  assign vld_pipe[0] = bus.in_valid && adv;

  always_ff @(posedge clk) begin
    if (rst)      vld_pipe[STAGES:1] <= '0;
    else if (adv) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_leaf
    logic [LEN_WIDTH-1:0] len_i;
    assign len_i = bus.in_len[i*LEN_WIDTH +: LEN_WIDTH];
`ifdef XBAR_SCHED_THRESH_EN
    assign ent_v[NUM_IN+i] = bus.in_mask[i] && (len_i >= bus.thresh);
`else
    assign ent_v[NUM_IN+i] = bus.in_mask[i];
`endif
    assign ent_len[NUM_IN+i] = len_i;
    assign ent_id[NUM_IN+i]  = ID_WIDTH'(i);
  end

  for (genvar k = 0; k < ID_WIDTH; k++) begin : g_lvl
    localparam int FIRST = 1 << k;
    localparam int CNT   = 1 << k;
    // Register after every PIPE_EVERY levels counted from the leaves; root always registered.
    localparam bit REG   = (((ID_WIDTH - k) % PIPE_EVERY) == 0) || (k == 0);

    for (genvar j = 0; j < CNT; j++) begin : g_node
      localparam int N = FIRST + j;
      xbar_sched_node #(
        .LEN_WIDTH(LEN_WIDTH),
        .ID_WIDTH (ID_WIDTH),
        .MIN_MODE (MIN_MODE)
      ) u_node (
        .a_v  (ent_v[2*N]),
        .a_len(ent_len[2*N]),
        .a_id (ent_id[2*N]),
        .b_v  (ent_v[2*N+1]),
        .b_len(ent_len[2*N+1]),
        .b_id (ent_id[2*N+1]),
        .y_v  (nd_v[N]),
        .y_len(nd_len[N]),
        .y_id (nd_id[N])
      );
    end

    if (REG) begin : g_reg
      logic [CNT-1:0][EW-1:0] q;

      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (adv) begin
          for (int j = 0; j < CNT; j++)
            q[j] <= {nd_v[FIRST+j], nd_len[FIRST+j], nd_id[FIRST+j]};
        end
      end

      for (genvar j = 0; j < CNT; j++) begin : g_out
        assign {ent_v[FIRST+j], ent_len[FIRST+j], ent_id[FIRST+j]} = q[j];
      end
    end else begin : g_wire
      assign ent_v[FIRST +: CNT]   = nd_v[FIRST +: CNT];
      assign ent_len[FIRST +: CNT] = nd_len[FIRST +: CNT];
      assign ent_id[FIRST +: CNT]  = nd_id[FIRST +: CNT];
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_found = ent_v[1];
  assign bus.out_len   = ent_len[1];
  assign bus.out_id    = ent_id[1];
endmodule

// File: tb/tb_xbar_sched_pipe.sv
// Directed bench for xbar_sched_pipe: max/min/tie/mask, backpressure, reset flush,
// and a 32-input PIPE_EVERY=2 instance streamed against a linear-scan model.
module tb_xbar_sched_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xbar_sched_if #(.LEN_WIDTH(4),  .ID_WIDTH(2)) a_if(), b_if();
  xbar_sched_if #(.LEN_WIDTH(10), .ID_WIDTH(5)) c_if();

  xbar_sched_pipe #(.LEN_WIDTH(4), .ID_WIDTH(2), .PIPE_EVERY(1), .MIN_MODE(0))
    u_max (.clk(clk), .rst(rst), .bus(a_if));
  xbar_sched_pipe #(.LEN_WIDTH(4), .ID_WIDTH(2), .PIPE_EVERY(1), .MIN_MODE(1))
    u_min (.clk(clk), .rst(rst), .bus(b_if));
  xbar_sched_pipe #(.LEN_WIDTH(10), .ID_WIDTH(5), .PIPE_EVERY(2), .MIN_MODE(0))
    u_big (.clk(clk), .rst(rst), .bus(c_if));

  assign b_if.in_valid  = a_if.in_valid;
  assign b_if.in_len    = a_if.in_len;
  assign b_if.in_mask   = a_if.in_mask;
  assign b_if.out_ready = a_if.out_ready;
`ifdef XBAR_SCHED_THRESH_EN
  assign b_if.thresh    = a_if.thresh;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic f, input logic [1:0] id, input logic [3:0] len);
    chk(tag, {25'd0, a_if.out_found, a_if.out_id, a_if.out_len}, {25'd0, f, id, len});
  endtask

  task automatic chk_b(input string tag, input logic f, input logic [1:0] id, input logic [3:0] len);
    chk(tag, {25'd0, b_if.out_found, b_if.out_id, b_if.out_len}, {25'd0, f, id, len});
  endtask

  // One vector through the 2-stage pipe; returns with its result on the outputs.
  task automatic vec(input logic [15:0] len, input logic [3:0] mask);
    a_if.in_valid = 1'b1;
    a_if.in_len   = len;
    a_if.in_mask  = mask;
    tick;
    a_if.in_valid = 1'b0;
    tick;
  endtask

  // Linear scan, first strictly-greater wins: {found, id[4:0], len[9:0]}.
  function automatic logic [15:0] ref_max(input logic [319:0] lv, input logic [31:0] mk);
    logic       f = 1'b0;
    logic [4:0] bid = '0;
    logic [9:0] bl = '0;
    for (int i = 0; i < 32; i++) begin
      if (mk[i] && (!f || lv[i*10 +: 10] > bl)) begin
        f = 1'b1;
        bid = 5'(i);
        bl = lv[i*10 +: 10];
      end
    end
    return {f, bid, bl};
  endfunction

  logic [15:0]  exq[$];
  logic [319:0] lv;
  logic [15:0]  got_c;

  initial begin
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_len = '0; a_if.in_mask = '0; a_if.out_ready = 1'b1;
    c_if.in_valid = 1'b0; c_if.in_len = '0; c_if.in_mask = '0; c_if.out_ready = 1'b1;
`ifdef XBAR_SCHED_THRESH_EN
    a_if.thresh = '0;
    c_if.thresh = '0;
`endif
    tick; tick;
    rst = 1'b0;

    chk("rst_out_valid", a_if.out_valid, 0);
    chk_a("rst_out_data", 0, 0, 0);
    chk("rst_in_ready", a_if.in_ready, 1);
    chk("rst_big_valid", c_if.out_valid, 0);

    // Basic max, latency 2
    a_if.in_valid = 1'b1; a_if.in_len = 16'h1593; a_if.in_mask = 4'hF;
    tick;
    a_if.in_valid = 1'b0;
    chk("lat_early", a_if.out_valid, 0);
    tick;
    chk("lat_valid", a_if.out_valid, 1);
    chk_a("basic_max", 1, 1, 9);
    chk_b("basic_min", 1, 3, 1);
    tick;
    chk("bubble", a_if.out_valid, 0);

    vec(16'h2777, 4'b1111); chk_a("tie_low_id", 1, 0, 7);
    vec(16'h2777, 4'b1110); chk_a("tie_masked", 1, 1, 7);
    vec(16'h2777, 4'b0000); chk_a("all_masked", 0, 0, 0);
    chk("all_masked_valid", a_if.out_valid, 1);
    chk_b("all_masked_min", 0, 0, 0);
    vec(16'h1593, 4'b0111); chk_b("min_mask", 1, 0, 3);
    chk_a("max_mask", 1, 1, 9);

    // Backpressure: v0..v3 = 1593, 6428, 4321, CC55
    tick;
    a_if.out_ready = 1'b1;
    a_if.in_valid = 1'b1; a_if.in_mask = 4'hF; a_if.in_len = 16'h1593;
    tick;
    a_if.in_len = 16'h6428;
    tick;
    a_if.out_ready = 1'b0; a_if.in_len = 16'h4321;
    #1;
    for (int h = 0; h < 3; h++) begin
      chk("bp_in_ready", a_if.in_ready, 0);
      chk("bp_valid", a_if.out_valid, 1);
      chk_a("bp_stable", 1, 1, 9);
      tick;
    end
    a_if.out_ready = 1'b1;
    #1;
    chk_a("bp_v0", 1, 1, 9);
    chk("bp_release_rdy", a_if.in_ready, 1);
    tick;
    chk_a("bp_v1", 1, 0, 8);
    a_if.in_len = 16'hCC55;
    tick;
    chk("bp_v2_valid", a_if.out_valid, 1);
    chk_a("bp_v2", 1, 3, 4);
    a_if.in_valid = 1'b0;
    tick;
    chk("bp_v3_valid", a_if.out_valid, 1);
    chk_a("bp_v3", 1, 2, 12);
    tick;
    chk("bp_no_dup", a_if.out_valid, 0);

    // Reset with two vectors in flight
    a_if.in_valid = 1'b1; a_if.in_len = 16'h6428;
    tick;
    a_if.in_len = 16'h4321;
    tick;
    a_if.in_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("rst_flush_valid", a_if.out_valid, 0);
    chk("rst_flush_found", a_if.out_found, 0);
    rst = 1'b0;
    for (int h = 0; h < 3; h++) begin
      tick;
      chk("rst_no_stale", a_if.out_valid, 0);
    end

`ifdef XBAR_SCHED_THRESH_EN
    a_if.thresh = 4'd10;
    vec(16'h1593, 4'hF); chk_a("thresh_10", 0, 0, 0);
    a_if.thresh = 4'd5;
    vec(16'h1593, 4'hF); chk_a("thresh_5", 1, 1, 9);
    a_if.thresh = '0;
    tick;
`endif

    // Big instance: latency 3
    for (int i = 0; i < 32; i++) lv[i*10 +: 10] = 10'(i);
    lv[170 +: 10] = 10'd1000;
    c_if.in_valid = 1'b1; c_if.in_len = lv; c_if.in_mask = '1;
    tick;
    c_if.in_valid = 1'b0;
    chk("big_lat1", c_if.out_valid, 0);
    tick;
    chk("big_lat2", c_if.out_valid, 0);
    tick;
    chk("big_lat3", c_if.out_valid, 1);
    chk("big_directed", {16'd0, c_if.out_found, c_if.out_id, c_if.out_len}, {16'd0, 1'b1, 5'd17, 10'd1000});
    tick;

    // Big instance: random stream with random backpressure
    for (int cyc = 0; cyc < 80; cyc++) begin
      for (int i = 0; i < 32; i++)
        lv[i*10 +: 10] = (cyc % 2 == 1) ? 10'($urandom_range(0, 3)) : 10'($urandom_range(0, 1023));
      c_if.in_len    = lv;
      c_if.in_mask   = (cyc % 7 == 3) ? 32'd0 : 32'($urandom);
      c_if.in_valid  = ($urandom_range(0, 3) != 0);
      c_if.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (c_if.out_valid && c_if.out_ready) begin
        got_c = {c_if.out_found, c_if.out_id, c_if.out_len};
        if (exq.size() == 0) chk("big_extra", 1, 0);
        else                 chk("big_stream", {16'd0, got_c}, {16'd0, exq.pop_front()});
      end
      if (c_if.in_valid && c_if.in_ready) exq.push_back(ref_max(c_if.in_len, c_if.in_mask));
      tick;
    end
    c_if.in_valid = 1'b0; c_if.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (c_if.out_valid) begin
        got_c = {c_if.out_found, c_if.out_id, c_if.out_len};
        if (exq.size() == 0) chk("big_extra", 1, 0);
        else                 chk("big_drain", {16'd0, got_c}, {16'd0, exq.pop_front()});
      end
      tick;
    end
    chk("big_all_delivered", exq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
